// File: rtl/dma_block_copy_if.sv
// rtl/dma_block_copy_if.sv - data-memory port bundle between the DMA initiator and the data memory
interface dma_block_copy_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_read,
        output mem_write,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_read,
        input  mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/dma_block_copy.sv
// rtl/dma_block_copy.sv - forward byte-block copy engine driving the data-memory port
// Optional running sum of written bytes on output checksum when CHECKSUM_EN is defined.
module dma_block_copy #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   length,
    dma_block_copy_if.master  mem,
    output logic              busy,
`ifdef CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output logic              done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] PTR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE = 1;

    logic [1:0]        state;
    logic [ADDR_W-1:0] src_ptr;
    logic [ADDR_W-1:0] dst_ptr;
    logic [ADDR_W:0]   count;
    logic [DATA_W-1:0] data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            src_ptr  <= '0;
            dst_ptr  <= '0;
            count    <= '0;
            data_reg <= '0;
`ifdef CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        src_ptr <= src_addr;
                        dst_ptr <= dst_addr;
                        count   <= length;
`ifdef CHECKSUM_EN
                        checksum <= '0;
`endif
                        state   <= (length == '0) ? DONE : READ;
                    end
                end
                READ: begin
                    data_reg <= mem.mem_rdata;
                    state    <= WRITE;
                end
                WRITE: begin
                    // Pointers wrap naturally at ADDR_W bits.
                    src_ptr <= src_ptr + PTR_ONE;
                    dst_ptr <= dst_ptr + PTR_ONE;
                    count   <= count - CNT_ONE;
`ifdef CHECKSUM_EN
                    checksum <= checksum + data_reg;
`endif
                    state   <= (count == CNT_ONE) ? DONE : READ;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            READ: begin
                mem.mem_addr = src_ptr;
                mem.mem_read = 1'b1;
                busy         = 1'b1;
            end
            WRITE: begin
                mem.mem_addr  = dst_ptr;
                mem.mem_wdata = data_reg;
                mem.mem_write = 1'b1;
                busy          = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_dma_block_copy.sv
// tb/tb_dma_block_copy.sv - scoreboard bench for dma_block_copy against a byte-array copy model
module tb_dma_block_copy;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] src_addr = '0;
    logic [7:0] dst_addr = '0;
    logic [8:0] length = '0;
    logic       busy;
    logic       done;
`ifdef CHECKSUM_EN
    logic [7:0] checksum;
`endif

    always #5 clk = ~clk;

    dma_block_copy_if mif ();

    dma_block_copy dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .src_addr (src_addr),
        .dst_addr (dst_addr),
        .length   (length),
        .mem      (mif),
        .busy     (busy),
`ifdef CHECKSUM_EN
        .checksum (checksum),
`endif
        .done     (done)
    );

    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];

    assign mif.mem_rdata = mem[mif.mem_addr];
    always @(posedge clk) if (mif.mem_write) mem[mif.mem_addr] <= mif.mem_wdata;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0]  rd_q [$];
    logic [15:0] wr_q [$];
    int          done_q [$];
    logic [7:0]  sum_q [$];

    int checks = 0;
    int errors = 0;
    logic prev_done = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference: a plain forward byte copy over a wrapping 256-byte array.
    function automatic void expect_xfer(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                                        input bit abort, input int nkeep, input int done_cyc);
        logic [7:0] sa, da, b, sum;
        sum = '0;
        for (int i = 0; i < int'(n); i++) begin
            sa = s + 8'(i);
            da = d + 8'(i);
            rd_q.push_back(sa);
            if (abort && i == nkeep) break;
            b = ref_mem[sa];
            wr_q.push_back({da, b});
            ref_mem[da] = b;
            sum = sum + b;
        end
        if (!abort) begin
            done_q.push_back(done_cyc);
            sum_q.push_back(sum);
        end
    endfunction

    always @(negedge clk) begin
        check("rw_exclusive", {31'd0, mif.mem_read & mif.mem_write}, 0);
        check("busy_decode", {31'd0, busy}, {31'd0, mif.mem_read | mif.mem_write});
        check("done_pulse", {31'd0, prev_done & done}, 0);
        if (!busy) begin
            check("idle_addr", {24'd0, mif.mem_addr}, 0);
            check("idle_wdata", {24'd0, mif.mem_wdata}, 0);
        end
        if (mif.mem_read) begin
            if (rd_q.size() == 0) check("unexpected_read", 1, 0);
            else check("read_addr", {24'd0, mif.mem_addr}, {24'd0, rd_q.pop_front()});
        end
        if (mif.mem_write) begin
            if (wr_q.size() == 0) check("unexpected_write", 1, 0);
            else check("write_addr_data", {16'd0, mif.mem_addr, mif.mem_wdata}, {16'd0, wr_q.pop_front()});
        end
        if (done) begin
            check("done_busy_low", {31'd0, busy}, 0);
            if (done_q.size() == 0) check("unexpected_done", 1, 0);
            else begin
                check("done_cycle", cyc, done_q.pop_front());
`ifdef CHECKSUM_EN
                check("checksum", {24'd0, checksum}, {24'd0, sum_q.pop_front()});
`endif
            end
        end
        prev_done <= done;
    end

    task automatic launch(input logic [7:0] s, input logic [7:0] d, input logic [8:0] n,
                          input bit abort, input int nkeep);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        length   = n;
        start    = 1'b1;
        expect_xfer(s, d, n, abort, nkeep, cyc + 1 + 2 * int'(n));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done_q.size() != 0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("done_timeout", {31'd0, t >= 3000}, 0);
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp1 [4];
        logic [7:0] s, d;
        logic [8:0] n;
        int t;
        exp1 = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        for (int i = 0; i < 4; i++) begin
            mem[10+i]     = exp1[i];
            ref_mem[10+i] = exp1[i];
        end

        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", {mif.mem_addr, mif.mem_wdata, 12'd0, mif.mem_read, mif.mem_write, busy, done}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        launch(8'd10, 8'd30, 9'd4, 1'b0, 0);
        wait_done();
        for (int i = 0; i < 4; i++) check("copy_basic", {24'd0, mem[30+i]}, {24'd0, exp1[i]});
`ifdef CHECKSUM_EN
        check("checksum_hold", {24'd0, checksum}, 32'h0E);
`endif

        launch(8'h55, 8'h66, 9'd0, 1'b0, 0);
        wait_done();

        launch(8'hFE, 8'h40, 9'd3, 1'b0, 0);
        wait_done();

        // Spurious start mid-transfer must not disturb the copy in flight.
        launch(8'h20, 8'h80, 9'd4, 1'b0, 0);
        @(negedge clk);
        src_addr = 8'h00;
        dst_addr = 8'h01;
        length   = 9'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Start held high across DONE->IDLE is taken at the first IDLE edge.
        launch(8'h90, 8'hA0, 9'd2, 1'b0, 0);
        t = 0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("held_done_seen", {31'd0, done}, 1);
        src_addr = 8'hB0;
        dst_addr = 8'hB3;
        length   = 9'd5;
        start    = 1'b1;
        expect_xfer(8'hB0, 8'hB3, 9'd5, 1'b0, 0, cyc + 2 + 2 * 5);
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done();

        // Reset during the second WRITE: only the first byte lands.
        launch(8'h60, 8'hC0, 9'd4, 1'b1, 1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_outputs", {mif.mem_addr, mif.mem_wdata, 12'd0, mif.mem_read, mif.mem_write, busy, done}, 0);
`ifdef CHECKSUM_EN
        check("abort_checksum", {24'd0, checksum}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int k = 0; k < 20; k++) begin
            s = 8'($urandom);
            d = 8'($urandom);
            n = ($urandom_range(0, 5) == 0) ? 9'($urandom_range(0, 2)) : 9'($urandom_range(1, 24));
            launch(s, d, n, 1'b0, 0);
            wait_done();
        end
        launch(8'($urandom), 8'($urandom), 9'd256, 1'b0, 0);
        wait_done();

        repeat (3) @(negedge clk);
        check("rd_q_empty", rd_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
        check("done_q_empty", done_q.size(), 0);
        for (int i = 0; i < 256; i++) check("final_mem", {24'd0, mem[i]}, {24'd0, ref_mem[i]});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
